fifo_wr_arbiter: RTL and testbench

Round-robin arbiter that shares the single write port of the asynchronous FIFO among `NUM_REQ` requesters in the write clock domain. Each requester presents bursts over a valid/ready handshake. The arbiter grants one requester at a time, holds the grant until the burst ends or `MAX_BURST` beats have been written, and drives the FIFO `wr_en`/`data_in` while honouring `full`. It also keeps a free-running count of accepted words for status readout.

---
 rtl/fifo_wr_arbiter.sv | 179 +++++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
//   Round-robin arbiter sharing the single write port of an asynchronous
//   FIFO among NUM_REQ requesters in the write clock domain. A grant is held
//   until the requester's last beat or until MAX_BURST beats have been
//   written, whichever comes first. It also keeps a wrapping count of every
//   word written into the FIFO.
//
// Ports
//   clk          write-domain clock
//   rst          synchronous active-high reset
//   req_valid    per-requester beat valid
//   req_last     per-requester last-beat flag (qualified by valid)
//   req_data     requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready    per-requester beat accept (combinational)
//   full         FIFO full flag
//   wr_en        FIFO write strobe (combinational)
//   data_in      FIFO write data (combinational, 0 when idle)
//   grant_valid  a requester holds the port (registered)
//   grant_id     index of the granted requester (registered)
//   preempt      one-cycle pulse after a MAX_BURST forced release
//   word_count   total accepted words, wraps modulo 2**CNT_WIDTH
// ---------------------------------------------------------------------------
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ-1:0]               req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic                             full,
    output logic                             wr_en,
    output logic [DATA_WIDTH-1:0]            data_in,
    output logic                             grant_valid,
    output logic [$clog2(NUM_REQ)-1:0]       grant_id,
    output logic                             preempt,
    output logic [CNT_WIDTH-1:0]             word_count
);

    localparam int ID_W = $clog2(NUM_REQ);
    localparam int BC_W = $clog2(MAX_BURST + 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t                state_q,      state_d;
    logic [ID_W-1:0]       grant_id_q,   grant_id_d;
    logic [ID_W-1:0]       rr_ptr_q,     rr_ptr_d;
    logic [BC_W-1:0]       beat_cnt_q,   beat_cnt_d;
    logic [CNT_WIDTH-1:0]  word_count_q, word_count_d;
    logic                  preempt_q,    preempt_d;

    logic                  pick_found_s;
    logic [ID_W-1:0]       pick_id_s;
    logic                  wr_en_s;
    logic [NUM_REQ-1:0]    req_ready_s;
    logic [DATA_WIDTH-1:0] data_in_s;
    logic                  limit_s;
    logic                  last_s;
    logic [ID_W-1:0]       next_ptr_s;

    // Round-robin search: scan offsets from far to near so the nearest valid
    // index to rr_ptr (the highest priority) is the one that sticks.
    always_comb begin
        logic [ID_W-1:0] cand;
        pick_found_s = 1'b0;
        pick_id_s    = '0;
        cand         = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (req_valid[cand]) begin
                pick_found_s = 1'b1;
                pick_id_s    = cand;
            end else begin
                pick_found_s = pick_found_s;
            end
        end
    end

    // Write-port datapath: only the granted requester sees ready, gated by full.
    always_comb begin
        req_ready_s = '0;
        wr_en_s     = 1'b0;
        data_in_s   = '0;
        if (state_q == ST_BUSY) begin
            req_ready_s[grant_id_q] = ~full;
            wr_en_s                 = req_valid[grant_id_q] & ~full;
            data_in_s               = req_data[grant_id_q*DATA_WIDTH +: DATA_WIDTH];
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Release helpers: this beat hits the burst limit / carries last.
    always_comb begin
        limit_s    = (beat_cnt_q == BC_W'(MAX_BURST - 1));
        last_s     = req_last[grant_id_q];
        if (grant_id_q == ID_W'(NUM_REQ - 1)) begin
            next_ptr_s = '0;
        end else begin
            next_ptr_s = grant_id_q + ID_W'(1);
        end
    end

    // Next-state logic for grant FSM, pointer, beat and word counters.
    always_comb begin
        state_d      = state_q;
        grant_id_d   = grant_id_q;
        rr_ptr_d     = rr_ptr_q;
        beat_cnt_d   = beat_cnt_q;
        word_count_d = word_count_q;
        preempt_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_found_s) begin
                    state_d    = ST_BUSY;
                    grant_id_d = pick_id_s;
                    beat_cnt_d = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (wr_en_s) begin
                    word_count_d = word_count_q + CNT_WIDTH'(1);
                    beat_cnt_d   = beat_cnt_q + BC_W'(1);
                    if (last_s || limit_s) begin
                        state_d   = ST_IDLE;
                        rr_ptr_d  = next_ptr_s;
                        // A last beat landing on the limit is an ordinary release.
                        preempt_d = limit_s & ~last_s;
                    end else begin
                        state_d = ST_BUSY;
                    end
                end else begin
                    state_d = ST_BUSY;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            grant_id_q   <= '0;
            rr_ptr_q     <= '0;
            beat_cnt_q   <= '0;
            word_count_q <= '0;
            preempt_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_id_q   <= grant_id_d;
            rr_ptr_q     <= rr_ptr_d;
            beat_cnt_q   <= beat_cnt_d;
            word_count_q <= word_count_d;
            preempt_q    <= preempt_d;
        end
    end

    assign req_ready   = req_ready_s;
    assign wr_en       = wr_en_s;
    assign data_in     = data_in_s;
    assign grant_valid = (state_q == ST_BUSY);
    assign grant_id    = grant_id_q;
    assign preempt     = preempt_q;
    assign word_count  = word_count_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//   Directed and randomized bench for fifo_wr_arbiter. Each requester owns a
//   queue of {data,last} words; a behavioural model tracks who owns the port,
//   the rotation point, beats in the current grant and the word total, and
//   predicts every output each cycle.
// ---------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 16;
    localparam int CW = 16;
    localparam int IW = $clog2(N);

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_last;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      req_ready;
    logic              full;
    logic              wr_en;
    logic [DW-1:0]     data_in;
    logic              grant_valid;
    logic [IW-1:0]     grant_id;
    logic              preempt;
    logic [CW-1:0]     word_count;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
        .req_ready(req_ready), .full(full),
        .wr_en(wr_en), .data_in(data_in),
        .grant_valid(grant_valid), .grant_id(grant_id),
        .preempt(preempt), .word_count(word_count)
    );

    // Requester-side burst queues.
    logic [DW-1:0] qd [N][$];
    logic          ql [N][$];

    // Behavioural model state.
    int            m_g;      // granted requester, -1 when none
    int            m_rr;     // highest-priority index
    int            m_beats;  // beats written in the current grant
    logic [CW-1:0] m_cnt;
    logic          m_pre;
    bit            m_known;

    // Stimulus controls and observation logs.
    int  full_sel;     // 0 low, 1 high, 2 random
    bit  rand_valid;
    bit  rst_cmd;
    int  pre_seen;
    bit  prev_gv;
    int  gq[$];

    int  n_cmp = 0;
    int  n_mis = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic push(input int r, input int n, input int base, input bit with_last);
        for (int i = 0; i < n; i++) begin
            qd[r].push_back(DW'(base + i));
            ql[r].push_back(with_last && (i == n - 1));
        end
    endtask

    function automatic bit pending();
        bit p = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (qd[i].size() > 0) p = 1'b1;
        end
        return p;
    endfunction

    // One clock: drive, check at negedge, advance model, wait past posedge.
    task automatic step();
        logic [N-1:0]  er;
        logic          ew;
        logic [DW-1:0] ed;
        bit            gv;
        bit            lb;
        for (int i = 0; i < N; i++) begin
            if (qd[i].size() > 0) begin
                req_valid[i]           = !rand_valid || ($urandom_range(0, 3) != 0);
                req_last[i]            = ql[i][0];
                req_data[i*DW +: DW]   = qd[i][0];
            end else begin
                req_valid[i]           = 1'b0;
                req_last[i]            = 1'($urandom_range(0, 1));
                req_data[i*DW +: DW]   = DW'($urandom);
            end
        end
        full = (full_sel == 2) ? ($urandom_range(0, 3) == 0) : (full_sel == 1);
        rst  = rst_cmd;
        @(negedge clk);
        if (preempt === 1'b1) pre_seen++;
        if (grant_valid === 1'b1 && !prev_gv) gq.push_back(int'(grant_id));
        prev_gv = (grant_valid === 1'b1);
        gv = 1'b0; ew = 1'b0; er = '0; ed = '0;
        if (m_known) begin
            gv = (m_g >= 0);
            if (gv) begin
                if (!full) er[m_g] = 1'b1;
                ew = req_valid[m_g] && !full;
                ed = req_data[m_g*DW +: DW];
            end
            chk("grant_valid", grant_valid, gv);
            if (gv) chk("grant_id", grant_id, m_g);
            chk("req_ready", req_ready, er);
            chk("wr_en", wr_en, ew);
            chk("data_in", data_in, ed);
            chk("preempt", preempt, m_pre);
            chk("word_count", word_count, m_cnt);
            // Requester sees its handshake even in a reset cycle.
            if (ew) begin
                lb = ql[m_g][0];
                void'(qd[m_g].pop_front());
                void'(ql[m_g].pop_front());
            end
        end
        if (rst_cmd) begin
            m_g = -1; m_rr = 0; m_beats = 0; m_cnt = '0; m_pre = 1'b0; m_known = 1'b1;
        end else if (m_known) begin
            m_pre = 1'b0;
            if (m_g < 0) begin
                for (int k = 0; k < N; k++) begin
                    if (m_g < 0 && req_valid[(m_rr + k) % N]) begin
                        m_g = (m_rr + k) % N;
                        m_beats = 0;
                    end
                end
            end else if (ew) begin
                m_cnt = m_cnt + 1'b1;
                m_beats++;
                if (lb || m_beats == MB) begin
                    m_pre = (m_beats == MB) && !lb;
                    m_rr  = (m_g + 1) % N;
                    m_g   = -1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget);
        int c = 0;
        while (pending() && c < budget) begin
            step();
            c++;
        end
        chk("drain_done", {31'd0, pending()}, 32'd0);
    endtask

    task automatic do_reset();
        rst_cmd = 1'b1;
        step();
        rst_cmd = 1'b0;
    endtask

    initial begin
        req_valid = '0; req_last = '0; req_data = '0; full = 1'b0; rst = 1'b1;
        m_known = 1'b0; m_g = -1; m_rr = 0; m_beats = 0; m_cnt = '0; m_pre = 1'b0;
        full_sel = 0; rand_valid = 1'b0; rst_cmd = 1'b1; pre_seen = 0; prev_gv = 1'b0;
        @(posedge clk); #1;
        step(); step();
        rst_cmd = 1'b0;
        chk("rst_grant_valid", grant_valid, 1'b0);
        chk("rst_word_count", word_count, 16'h0000);
        chk("rst_preempt", preempt, 1'b0);

        // Single 3-beat burst from requester 0.
        push(0, 3, 8'hA1, 1'b1);
        drain(50);
        chk("t1_word_count", word_count, 16'd3);
        step(); step();

        // All four with back-to-back 1-beat bursts: strict rotation.
        do_reset();
        gq.delete();
        for (int rep = 0; rep < 2; rep++)
            for (int r = 0; r < N; r++) push(r, 1, 8'h10 * (r + 1) + rep, 1'b1);
        drain(100);
        step(); step();
        chk("t2_grant_count", gq.size(), 8);
        for (int k = 0; k < 8 && k < gq.size(); k++) chk("t2_grant_order", gq[k], k % N);

        // 20 beats without last from requester 2 competing with the others.
        do_reset();
        pre_seen = 0;
        push(2, 20, 8'h20, 1'b0);
        push(0, 1, 8'h01, 1'b1);
        push(1, 1, 8'h02, 1'b1);
        push(3, 1, 8'h03, 1'b1);
        drain(200);
        step(); step(); step();
        chk("t3_preempt_pulses", pre_seen, 1);
        chk("t3_word_count", word_count, 16'd23);

        // full held for 5 cycles in the middle of a burst.
        do_reset();
        push(1, 8, 8'h40, 1'b1);
        step(); step(); step();
        full_sel = 1;
        for (int i = 0; i < 5; i++) step();
        full_sel = 0;
        drain(100);
        chk("t4_word_count", word_count, 16'd8);

        // Reset in the middle of a burst; next grant goes to the lowest valid.
        push(3, 10, 8'h60, 1'b1);
        for (int i = 0; i < 4; i++) step();
        rst_cmd = 1'b1;
        push(1, 2, 8'h70, 1'b1);
        step();
        rst_cmd = 1'b0;
        chk("t5_grant_valid", grant_valid, 1'b0);
        chk("t5_word_count", word_count, 16'h0000);
        chk("t5_wr_en", wr_en, 1'b0);
        gq.delete(); prev_gv = 1'b0;
        drain(100);
        chk("t5_first_grant", (gq.size() > 0) ? gq[0] : -1, 1);

        // Randomized traffic with random valid gaps and full.
        rand_valid = 1'b1; full_sel = 2;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 7) == 0)
                push($urandom_range(0, N - 1), $urandom_range(1, 24), $urandom_range(0, 255), 1'b1);
            step();
        end
        drain(5000);
        rand_valid = 1'b0; full_sel = 0;
        step(); step();

        // Counter wrap: 65536 words end at 0x0000.
        do_reset();
        for (int b = 0; b < 4096; b++) push(0, MB, b, 1'b1);
        drain(80000);
        step();
        chk("t6_word_count_wrap", word_count, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
